// File: rtl/appr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : appr_pkg
// Brief    : Shared defaults and FSM state type for the approximate-multiplier
//            datapath and the product accumulator.
// Revision : 1.0 - initial release
// ============================================================================
package appr_pkg;

    localparam int INPUT_WIDTH = 16;
    localparam int SHIFT_WIDTH = 8;
    localparam int PROD_WIDTH  = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } appr_state_e;

endpackage
`default_nettype wire

// File: rtl/appr_sat_add.sv
`default_nettype none
// ============================================================================
// Module   : appr_sat_add
// Brief    : Combinational two's-complement adder. With APPR_ACCUM_SAT_EN the
//            result clamps to the signed range and ovf flags the clamp;
//            otherwise it wraps and ovf is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module appr_sat_add #(
    parameter int WIDTH = 40
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             ovf
);

`ifdef APPR_ACCUM_SAT_EN
    logic [WIDTH:0] w_full;

    assign w_full = {a[WIDTH-1], a} + {b[WIDTH-1], b};

    // The guard bit disagreeing with the sign bit means the true sum left the range
    always_comb begin
        sum = w_full[WIDTH-1:0];
        ovf = 1'b0;
        if (w_full[WIDTH] != w_full[WIDTH-1]) begin
            ovf = 1'b1;
            sum = w_full[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign sum = a + b;
    assign ovf = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/appr_prod_accum.sv
`default_nettype none
// ============================================================================
// Module   : appr_prod_accum
// Brief    : Sums LEN rescaled signed products per frame and presents the sum
//            with a valid/ready handshake. Macro APPR_ACCUM_SAT_EN selects
//            saturating accumulation with a sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module appr_prod_accum #(
    parameter int PROD_WIDTH  = appr_pkg::PROD_WIDTH,
    parameter int SHIFT_WIDTH = appr_pkg::SHIFT_WIDTH,
    parameter int ACC_WIDTH   = 40,
    parameter int LEN         = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PROD_WIDTH-1:0] in_prod,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_WIDTH-1:0]  out_sum,
    output logic                  out_ovf
);
    import appr_pkg::*;

    localparam int c_CNT_W = $clog2(LEN + 1);

    appr_state_e          state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [c_CNT_W-1:0]   count_q, count_d;
    logic                 ovf_q, ovf_d;

    logic [ACC_WIDTH-1:0] w_term;
    logic [ACC_WIDTH-1:0] w_sum;
    logic                 w_add_ovf;
    logic                 w_accept;
    logic                 w_unused_lsb;

    // Dropping the low bits of a signed value is an arithmetic shift with floor rounding
    assign w_term       = ACC_WIDTH'($signed(in_prod[PROD_WIDTH-1:SHIFT_WIDTH]));
    assign w_unused_lsb = ^in_prod[SHIFT_WIDTH-1:0];

    appr_sat_add #(
        .WIDTH (ACC_WIDTH)
    ) u_add (
        .a   (acc_q),
        .b   (w_term),
        .sum (w_sum),
        .ovf (w_add_ovf)
    );

    assign in_ready  = (state_q != ST_HOLD);
    assign out_valid = (state_q == ST_HOLD);
    assign out_sum   = acc_q;
    assign out_ovf   = ovf_q;
    assign w_accept  = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (w_accept) begin
                    acc_d   = w_sum;
                    count_d = count_q + c_CNT_W'(1);
                    ovf_d   = ovf_q | w_add_ovf;
                    state_d = (count_q == c_CNT_W'(LEN - 1)) ? ST_HOLD : ST_ACCUM;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_appr_prod_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_appr_prod_accum
// Brief    : Self-checking bench: directed frames, backpressure, reset cases,
//            overflow behaviour and a random stream against a frame-sum model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_appr_prod_accum;

    localparam int LEN = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, out_ovf;
    logic [31:0] in_prod;
    logic [39:0] out_sum;

    logic        v2, in_ready2, out_valid2, rdy2, out_ovf2;
    logic [31:0] p2;
    logic [23:0] out_sum2;

    int          n_cmp = 0;
    int          n_err = 0;

    longint      m_acc;
    int          m_n;
    bit          m_hold;

    always #5 clk = ~clk;

    appr_prod_accum #(.PROD_WIDTH(32), .SHIFT_WIDTH(8), .ACC_WIDTH(40), .LEN(LEN)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_ovf(out_ovf)
    );

    appr_prod_accum #(.PROD_WIDTH(32), .SHIFT_WIDTH(8), .ACC_WIDTH(24), .LEN(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(v2), .in_ready(in_ready2), .in_prod(p2),
        .out_valid(out_valid2), .out_ready(rdy2), .out_sum(out_sum2), .out_ovf(out_ovf2)
    );

    function automatic longint term_of(input logic [31:0] p);
        longint s;
        longint q;
        s = longint'($signed(p));
        q = s / 256;
        if ((s % 256 != 0) && (s < 0)) q = q - 1;
        return q;
    endfunction

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: check outputs mid-cycle, then advance the model over the edge
    task automatic cyc(input bit r, input bit v, input logic [31:0] p, input bit ordy);
        rst = r; in_valid = v; in_prod = p; out_ready = ordy;
        @(negedge clk);
        chk("in_ready",  in_ready,  !m_hold);
        chk("out_valid", out_valid, m_hold);
        chk("out_sum",   $signed(out_sum), m_acc);
        chk("out_ovf",   out_ovf,   0);
        if (r) begin
            m_acc = 0; m_n = 0; m_hold = 0;
        end else if (m_hold) begin
            if (ordy) begin m_acc = 0; m_n = 0; m_hold = 0; end
        end else if (v) begin
            m_acc += term_of(p);
            m_n++;
            if (m_n == LEN) m_hold = 1;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        longint full, exp2;
        bit     exp_ovf2;

        rst = 1'b1; in_valid = 1'b0; in_prod = '0; out_ready = 1'b0;
        v2 = 1'b0; p2 = '0; rdy2 = 1'b0;
        m_acc = 0; m_n = 0; m_hold = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        cyc(0, 0, 32'h0, 0);

        // Positive frame: four 0x100 products sum to 4
        repeat (4) cyc(0, 1, 32'h0000_0100, 0);
        cyc(0, 0, 32'h0, 1);
        cyc(0, 0, 32'h0, 0);

        // Floor rounding on negative products
        cyc(0, 1, 32'hFFFF_FF00, 0);
        cyc(0, 1, 32'hFFFF_FF00, 0);
        cyc(0, 1, 32'hFFFF_FFFF, 0);
        cyc(0, 1, 32'hFFFF_FFFF, 0);
        // Backpressure with offered input held off during HOLD
        repeat (3) cyc(0, 1, 32'h0001_0000, 0);
        cyc(0, 1, 32'h0001_0000, 1);
        cyc(0, 0, 32'h0, 0);

        // Reset mid-frame discards the partial sum
        cyc(0, 1, 32'h0000_5000, 0);
        cyc(0, 1, 32'h0000_5000, 0);
        cyc(1, 0, 32'h0, 0);
        repeat (4) cyc(0, 1, 32'h0000_0100, 0);
        cyc(0, 0, 32'h0, 0);
        // Reset wins over a simultaneous transfer and accept
        cyc(1, 1, 32'h0000_0700, 1);
        cyc(0, 0, 32'h0, 0);

        // Random stream with input gaps and random backpressure
        for (int i = 0; i < 400; i++) begin
            cyc(0, ($urandom_range(0, 9) < 7), $urandom, $urandom_range(0, 1));
        end
        in_valid = 1'b0; out_ready = 1'b0;

        // Overflow case on the narrow instance
        full = 2 * term_of(32'h7FFF_FFFF);
`ifdef APPR_ACCUM_SAT_EN
        exp2     = (full > 64'sd8388607) ? 64'sd8388607 : full;
        exp_ovf2 = (full > 64'sd8388607);
`else
        exp2 = full & 64'hFF_FFFF;
        if (exp2 >= 64'sd8388608) exp2 -= 64'sd16777216;
        exp_ovf2 = 1'b0;
`endif
        v2 = 1'b1; p2 = 32'h7FFF_FFFF; rdy2 = 1'b0;
        @(negedge clk);
        chk("ovf_in_ready", in_ready2, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("ovf_mid_valid", out_valid2, 0);
        @(posedge clk); #1;
        v2 = 1'b0;
        @(negedge clk);
        chk("ovf_valid", out_valid2, 1);
        chk("ovf_sum",   $signed(out_sum2), exp2);
        chk("ovf_flag",  out_ovf2, exp_ovf2);
        chk("ovf_ready_hold", in_ready2, 0);
        rdy2 = 1'b1;
        @(posedge clk); #1;
        rdy2 = 1'b0;
        @(negedge clk);
        chk("ovf_clr_valid", out_valid2, 0);
        chk("ovf_clr_sum",   $signed(out_sum2), 0);
        chk("ovf_clr_flag",  out_ovf2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
